// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: WIDTH-bit operands, CHUNK bits per clock, MSB chunk first.
// Optional build macro CMP_EARLY_EXIT_EN finishes on the first differing chunk.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [2:0]       R
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  logic [IDX_W-1:0] idx;
  logic             gt_f, lt_f;

  logic             flip;
  logic [CHUNK-1:0] a_c, b_c;
  logic             gt_n, lt_n;
  logic             last;

  // Select chunk i; in signed mode the top chunk's MSB is inverted (offset binary).
  function automatic logic [CHUNK-1:0] chunk_of(input logic [WIDTH-1:0] v,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic flip_msb);
    logic [WIDTH-1:0] sh;
    logic [CHUNK-1:0] c;
    sh = v >> (int'(i) * CHUNK);
    c  = sh[CHUNK-1:0];
    if (flip_msb) c[CHUNK-1] = ~c[CHUNK-1];
    return c;
  endfunction

  always_comb begin
    flip = sm_q && (idx == TOP_IDX);
    a_c  = chunk_of(a_q, idx, flip);
    b_c  = chunk_of(b_q, idx, flip);
    gt_n = gt_f;
    lt_n = lt_f;
    if (!gt_f && !lt_f) begin
      if (a_c > b_c)      gt_n = 1'b1;
      else if (a_c < b_c) lt_n = 1'b1;
    end
`ifdef CMP_EARLY_EXIT_EN
    last = (idx == '0) || gt_n || lt_n;
`else
    last = (idx == '0);
`endif
  end

  // Operand capture: data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_q  <= A;
      b_q  <= B;
      sm_q <= signed_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      R     <= 3'b000;
      gt_f  <= 1'b0;
      lt_f  <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= TOP_IDX;
            gt_f  <= 1'b0;
            lt_f  <= 1'b0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          gt_f <= gt_n;
          lt_f <= lt_n;
          if (idx != '0) idx <= idx - 1'b1;
          if (last) begin
            R     <= {gt_n, ~gt_n & ~lt_n, lt_n};
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
